// File: rtl/shift_port_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// shift_port_ctrl
//
// I/O-port front end for the 8-bit barrel shifter. The shifter is two chained
// 8-bit registers plus a 3-bit offset. CPU IN/OUT accesses arrive over a
// 4-phase req/ack handshake and are decoded into one of three actions:
//   OUT AMT_PORT  : load the shift amount from wdata[2:0]
//   OUT DATA_PORT : push a byte into the shifter (one-cycle write strobe)
//   IN  RES_PORT  : return the shifted result byte
// An IN from any other port returns 0x00. An OUT to any other port has no
// effect. Both are still acknowledged.
//
// Build option:
//   SHIFT_DBG_PORT_EN  adds a second requester (dbg_*). It shares the shifter
//                      with the CPU under round-robin arbitration. When the
//                      macro is undefined, the CPU is the only requester and
//                      the handshake timing does not change.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cpu_req/we/port/wdata  CPU request, direction, port number, write data
//   cpu_ack, cpu_rdata     CPU handshake ack and read data
//   dbg_*                  same as cpu_*, present only with SHIFT_DBG_PORT_EN
//   sr_wdata, sr_wenable   byte and one-cycle write strobe to the shifter
//   sr_shift_amount        registered shift amount to the shifter
//   sr_shift_result        shifter result byte (combinational in the shifter)
//   busy                   high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module shift_port_ctrl #(
    parameter logic [7:0] AMT_PORT  = 8'd2,
    parameter logic [7:0] RES_PORT  = 8'd3,
    parameter logic [7:0] DATA_PORT = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_port,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
`ifdef SHIFT_DBG_PORT_EN
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [7:0] dbg_port,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_ack,
    output logic [7:0] dbg_rdata,
`endif
    output logic [7:0] sr_wdata,
    output logic       sr_wenable,
    output logic [2:0] sr_shift_amount,
    input  logic [7:0] sr_shift_result,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_t;

    state_t     state;
    req_id_t    grant;        // requester that owns the current transaction
    logic       lat_we;       // request fields captured at grant time
    logic [7:0] lat_port;
    logic [7:0] lat_wdata;
    logic       wen_q;

`ifdef SHIFT_DBG_PORT_EN
    req_id_t    last_grant;
`endif

    // Arbitration and request selection, used only while IDLE.
    logic       any_req;
    req_id_t    next_grant;
    logic       sel_we;
    logic [7:0] sel_port;
    logic [7:0] sel_wdata;
    logic       granted_req;  // req line of the requester that owns ACK

    // NOTE: every always_comb output gets a default first, so that no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        any_req     = cpu_req;
        next_grant  = REQ_CPU;
        sel_we      = cpu_we;
        sel_port    = cpu_port;
        sel_wdata   = cpu_wdata;
        granted_req = cpu_req;
`ifdef SHIFT_DBG_PORT_EN
        any_req = cpu_req | dbg_req;
        // DBG wins a tie only when the CPU had the previous grant.
        if (dbg_req && (!cpu_req || last_grant == REQ_CPU)) begin
            next_grant = REQ_DBG;
            sel_we     = dbg_we;
            sel_port   = dbg_port;
            sel_wdata  = dbg_wdata;
        end
        if (grant == REQ_DBG) begin
            granted_req = dbg_req;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together at the clock edge, whatever order the
    // statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            grant           <= REQ_CPU;
            lat_we          <= 1'b0;
            lat_port        <= 8'h00;
            lat_wdata       <= 8'h00;
            wen_q           <= 1'b0;
            sr_wdata        <= 8'h00;
            sr_shift_amount <= 3'd0;
            cpu_ack         <= 1'b0;
            cpu_rdata       <= 8'h00;
`ifdef SHIFT_DBG_PORT_EN
            dbg_ack         <= 1'b0;
            dbg_rdata       <= 8'h00;
            last_grant      <= REQ_DBG;   // the CPU wins the first tie
`endif
        end else begin
            // The strobe is raised only on entry to EXEC, so it lasts
            // exactly that one cycle.
            wen_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant     <= next_grant;
                        lat_we    <= sel_we;
                        lat_port  <= sel_port;
                        lat_wdata <= sel_wdata;
`ifdef SHIFT_DBG_PORT_EN
                        last_grant <= next_grant;
`endif
                        // Register the strobe now so that it is high during
                        // EXEC. The shifter then writes at the end of EXEC.
                        if (sel_we && sel_port == DATA_PORT) begin
                            wen_q    <= 1'b1;
                            sr_wdata <= sel_wdata;
                        end
                        state <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (lat_we) begin
                        if (lat_port == AMT_PORT) begin
                            sr_shift_amount <= lat_wdata[2:0];
                        end
                    end else begin
`ifdef SHIFT_DBG_PORT_EN
                        if (grant == REQ_DBG) begin
                            dbg_rdata <= (lat_port == RES_PORT) ? sr_shift_result : 8'h00;
                        end else begin
                            cpu_rdata <= (lat_port == RES_PORT) ? sr_shift_result : 8'h00;
                        end
`else
                        cpu_rdata <= (lat_port == RES_PORT) ? sr_shift_result : 8'h00;
`endif
                    end
                    state <= S_ACK;
                end

                S_ACK: begin
                    // First ACK cycle: raise ack. After that, hold ack until
                    // the owner drops its req, then release it and go idle.
`ifdef SHIFT_DBG_PORT_EN
                    if (grant == REQ_DBG) begin
                        if (!dbg_ack) begin
                            dbg_ack <= 1'b1;
                        end else if (!granted_req) begin
                            dbg_ack <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end else begin
                        if (!cpu_ack) begin
                            cpu_ack <= 1'b1;
                        end else if (!granted_req) begin
                            cpu_ack <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
`else
                    if (!cpu_ack) begin
                        cpu_ack <= 1'b1;
                    end else if (!granted_req) begin
                        cpu_ack <= 1'b0;
                        state   <= S_IDLE;
                    end
`endif
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // A reset that arrives during EXEC must stop the pending shifter write
    // at that same edge. The registered strobe is therefore masked by rst.
    assign sr_wenable = wen_q & ~rst;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_shift_port_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_shift_port_ctrl
//
// Directed testbench for shift_port_ctrl. It models the barrel shifter the
// controller drives. Each write pushes the new byte into hi, and the old hi
// moves into lo. The result byte is the upper byte of {hi,lo} << amount.
// Outputs are sampled 1 ns after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_shift_port_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_port = 8'h00;
    logic [7:0] cpu_wdata = 8'h00;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
`ifdef SHIFT_DBG_PORT_EN
    logic       dbg_req = 1'b0;
    logic       dbg_we = 1'b0;
    logic [7:0] dbg_port = 8'h00;
    logic [7:0] dbg_wdata = 8'h00;
    logic       dbg_ack;
    logic [7:0] dbg_rdata;
`endif
    logic [7:0] sr_wdata;
    logic       sr_wenable;
    logic [2:0] sr_shift_amount;
    logic [7:0] sr_shift_result;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int wen_edges = 0;

    // Shifter model
    logic [7:0] sh_hi = 8'h00;
    logic [7:0] sh_lo = 8'h00;

    function automatic logic [7:0] shifted(input logic [7:0] h, input logic [7:0] l,
                                           input logic [2:0] a);
        logic [15:0] c;
        c = {h, l} << a;
        return c[15:8];
    endfunction

    assign sr_shift_result = shifted(sh_hi, sh_lo, sr_shift_amount);

    always @(posedge clk) begin
        if (sr_wenable) begin
            sh_lo     <= sh_hi;
            sh_hi     <= sr_wdata;
            wen_edges <= wen_edges + 1;
        end
    end

    shift_port_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_port        (cpu_port),
        .cpu_wdata       (cpu_wdata),
        .cpu_ack         (cpu_ack),
        .cpu_rdata       (cpu_rdata),
`ifdef SHIFT_DBG_PORT_EN
        .dbg_req         (dbg_req),
        .dbg_we          (dbg_we),
        .dbg_port        (dbg_port),
        .dbg_wdata       (dbg_wdata),
        .dbg_ack         (dbg_ack),
        .dbg_rdata       (dbg_rdata),
`endif
        .sr_wdata        (sr_wdata),
        .sr_wenable      (sr_wenable),
        .sr_shift_amount (sr_shift_amount),
        .sr_shift_result (sr_shift_result),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // Runs one complete CPU transaction. lat is the number of edges from req
    // to ack (20 means it timed out). drop_ok is set when ack and busy are
    // both low one edge after req drops.
    task automatic txn(input logic we, input logic [7:0] port, input logic [7:0] wd,
                       output logic [7:0] rd, output int lat, output logic drop_ok);
        @(posedge clk); #1;
        cpu_we = we; cpu_port = port; cpu_wdata = wd; cpu_req = 1'b1;
        lat = 0;
        while (!cpu_ack && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = cpu_rdata;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        drop_ok = !cpu_ack && !busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", cpu_ack); end
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", cpu_rdata); end
        checks++; if (sr_wenable !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", sr_wenable); end
        checks++; if (sr_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", sr_wdata); end
        checks++; if (sr_shift_amount !== 3'd0) begin errors++; $display("FAIL reset_amt: got %0d want 0", sr_shift_amount); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
    endtask

    // Reset asserted during EXEC of OUT 4 aborts the transaction, and no
    // write reaches the shifter.
    task automatic test_reset_abort();
        int base;
        base = wen_edges;
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_port = 8'd4; cpu_wdata = 8'h11; cpu_req = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_exec: busy got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0; cpu_req = 1'b0;
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL abort_ack: got %b want 0", cpu_ack); end
        checks++; if (sr_wdata !== 8'h00) begin errors++; $display("FAIL abort_wdata: got %h want 00", sr_wdata); end
        checks++; if (sr_wenable !== 1'b0) begin errors++; $display("FAIL abort_wen: got %b want 0", sr_wenable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (wen_edges !== base) begin errors++; $display("FAIL abort_no_write: writes got %0d want %0d", wen_edges, base); end
        checks++; if (sh_hi !== 8'h00) begin errors++; $display("FAIL abort_shifter: hi got %h want 00", sh_hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy got %b want 0", busy); end
    endtask

    // OUT 4 AB, OUT 4 CD, OUT 2 03, IN 3 gives 0x6D (0xCDAB << 3, upper byte).
    task automatic test_shift_sequence();
        logic       we_t[4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] port_t[4] = '{8'd4, 8'd4, 8'd2, 8'd3};
        logic [7:0] wd_t[4]   = '{8'hAB, 8'hCD, 8'h03, 8'h00};
        logic [7:0] rd;
        int lat;
        logic dok;
        for (int i = 0; i < 4; i++) begin
            txn(we_t[i], port_t[i], wd_t[i], rd, lat, dok);
            checks++; if (lat !== 3) begin errors++; $display("FAIL seq_latency[%0d]: got %0d want 3", i, lat); end
            checks++; if (dok !== 1'b1) begin errors++; $display("FAIL seq_ack_drop[%0d]: got %b want 1", i, dok); end
        end
        checks++; if (rd !== 8'h6D) begin errors++; $display("FAIL seq_result: got %h want 6d", rd); end
    endtask

    task automatic test_amount();
        logic [7:0] rd;
        int lat;
        logic dok;
        txn(1'b1, 8'd2, 8'hFD, rd, lat, dok);
        checks++; if (sr_shift_amount !== 3'd5) begin errors++; $display("FAIL amt_mask: got %0d want 5", sr_shift_amount); end
        txn(1'b1, 8'd2, 8'h00, rd, lat, dok);
        txn(1'b0, 8'd3, 8'h00, rd, lat, dok);
        checks++; if (rd !== 8'hCD) begin errors++; $display("FAIL amt0_result: got %h want cd", rd); end
        txn(1'b1, 8'd2, 8'h07, rd, lat, dok);
        txn(1'b0, 8'd3, 8'h00, rd, lat, dok);
        checks++; if (rd !== 8'hD5) begin errors++; $display("FAIL amt7_result: got %h want d5", rd); end
    endtask

    task automatic test_other_ports();
        logic [7:0] rd;
        int lat;
        logic dok;
        int base;
        txn(1'b0, 8'd7, 8'h00, rd, lat, dok);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL in7_rdata: got %h want 00", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL in7_latency: got %0d want 3", lat); end
        base = wen_edges;
        txn(1'b1, 8'd9, 8'h55, rd, lat, dok);
        checks++; if (lat !== 3) begin errors++; $display("FAIL out9_latency: got %0d want 3", lat); end
        checks++; if (wen_edges !== base) begin errors++; $display("FAIL out9_no_write: writes got %0d want %0d", wen_edges, base); end
        checks++; if (sr_shift_result !== 8'hD5) begin errors++; $display("FAIL out9_result: got %h want d5", sr_shift_result); end
    endtask

    // Hold req past ack. Also change wdata/port mid-handshake; the latched
    // values must still be used.
    task automatic test_hold_req();
        int base;
        int lat;
        base = wen_edges;
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_port = 8'd4; cpu_wdata = 8'h77; cpu_req = 1'b1;
        lat = 0;
        while (!cpu_ack && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                cpu_wdata = 8'hEE;
                cpu_port  = 8'd2;
            end
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL hold_latency: got %0d want 3", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (cpu_ack !== 1'b1 || busy !== 1'b1) begin
                errors++; $display("FAIL hold_ack[%0d]: ack/busy got %b%b want 11", i, cpu_ack, busy);
            end
        end
        checks++; if (wen_edges !== base + 1) begin errors++; $display("FAIL hold_one_write: writes got %0d want %0d", wen_edges, base + 1); end
        checks++; if (sh_hi !== 8'h77) begin errors++; $display("FAIL hold_latched_data: hi got %h want 77", sh_hi); end
        checks++; if (sr_shift_amount !== 3'd7) begin errors++; $display("FAIL hold_amt_kept: got %0d want 7", sr_shift_amount); end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_release: ack/busy got %b%b want 00", cpu_ack, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || wen_edges !== base + 1) begin
            errors++; $display("FAIL hold_no_retrigger: busy %b writes %0d want 0 and %0d", busy, wen_edges, base + 1);
        end
    endtask

`ifdef SHIFT_DBG_PORT_EN
    // Both requesters ask again as soon as they are served, so every
    // arbitration is a tie. The grants must alternate.
    task automatic test_round_robin();
        logic exp_dbg[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic got_dbg;
        int n;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_port = 8'd7; dbg_we = 1'b0; dbg_port = 8'd7;
        cpu_req = 1'b1; dbg_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!cpu_ack && !dbg_ack && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            got_dbg = dbg_ack;
            checks++; if (n >= 20 || got_dbg !== exp_dbg[g]) begin
                errors++; $display("FAIL rr_grant[%0d]: got dbg=%b want dbg=%b (wait %0d)", g, got_dbg, exp_dbg[g], n);
            end
            if (got_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
            @(posedge clk); #1;
            if (g < 3) begin
                if (got_dbg) dbg_req = 1'b1; else cpu_req = 1'b1;
            end
        end
        n = 0;
        while (!cpu_ack && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rr_pending_cpu: ack got %b want 1", cpu_ack); end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: busy got %b want 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_abort();
        test_shift_sequence();
        test_amount();
        test_other_ports();
        test_hold_req();
`ifdef SHIFT_DBG_PORT_EN
        test_round_robin();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
